// File: rtl/seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_driver
// Purpose  : Latches CPU-written 32-bit words and scans them as hex glyphs
//            across an 8-digit multiplexed 7-segment display.
// Options  : SEG_BLANK_LEADING_ZERO_EN - blank leading-zero digits 7..1
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_driver #(
    parameter int SCAN_DIV   = 50000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seg_wen,
    input  logic [31:0] seg_wdata,
    output logic [7:0]  seg_out,
    output logic [7:0]  an_out
);

    localparam int              CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] C_DIV_MAX = CNT_W'(SCAN_DIV - 1);
    localparam logic [7:0]      C_OFF     = ACTIVE_LOW ? 8'hFF : 8'h00;

    logic [31:0]      disp_q,    disp_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [2:0]       idx_q,     idx_d;
    logic [7:0]       seg_q,     seg_d;
    logic [7:0]       an_q,      an_d;

    logic [3:0]       w_nibble;
    logic             w_blank;
    logic [7:0]       w_seg_raw;
    logic [7:0]       w_an_raw;
`ifdef SEG_BLANK_LEADING_ZERO_EN
    logic [31:0]      w_upper;
`endif

    function automatic logic [6:0] hex_glyph(input logic [3:0] nib);
        case (nib)
            4'h0: hex_glyph = 7'h3F;
            4'h1: hex_glyph = 7'h06;
            4'h2: hex_glyph = 7'h5B;
            4'h3: hex_glyph = 7'h4F;
            4'h4: hex_glyph = 7'h66;
            4'h5: hex_glyph = 7'h6D;
            4'h6: hex_glyph = 7'h7D;
            4'h7: hex_glyph = 7'h07;
            4'h8: hex_glyph = 7'h7F;
            4'h9: hex_glyph = 7'h6F;
            4'hA: hex_glyph = 7'h77;
            4'hB: hex_glyph = 7'h7C;
            4'hC: hex_glyph = 7'h39;
            4'hD: hex_glyph = 7'h5E;
            4'hE: hex_glyph = 7'h79;
            default: hex_glyph = 7'h71;
        endcase
    endfunction

    always_comb begin
        disp_d = seg_wen ? seg_wdata : disp_q;

        if (div_cnt_q == C_DIV_MAX) begin
            div_cnt_d = '0;
            idx_d     = idx_q + 3'd1;
        end else begin
            div_cnt_d = div_cnt_q + CNT_W'(1);
            idx_d     = idx_q;
        end

        w_nibble = disp_q[{idx_q, 2'b00} +: 4];
`ifdef SEG_BLANK_LEADING_ZERO_EN
        // Digit i is a leading zero when every nibble from i upward is zero.
        w_upper = disp_q >> {idx_q, 2'b00};
        w_blank = (idx_q != 3'd0) && (w_upper == 32'd0);
`else
        w_blank = 1'b0;
`endif

        w_seg_raw = w_blank ? 8'h00 : {1'b0, hex_glyph(w_nibble)};
        w_an_raw  = w_blank ? 8'h00 : (8'(1) << idx_q);
        seg_d     = ACTIVE_LOW ? ~w_seg_raw : w_seg_raw;
        an_d      = ACTIVE_LOW ? ~w_an_raw  : w_an_raw;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            disp_q    <= 32'd0;
            div_cnt_q <= '0;
            idx_q     <= 3'd0;
            seg_q     <= C_OFF;
            an_q      <= C_OFF;
        end else begin
            disp_q    <= disp_d;
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign seg_out = seg_q;
    assign an_out  = an_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_driver
// Purpose  : Directed self-checking bench for seg_scan_driver (SCAN_DIV=4,
//            ACTIVE_LOW=1); honours SEG_BLANK_LEADING_ZERO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_driver;

    logic        clk;
    logic        rst;
    logic        seg_wen;
    logic [31:0] seg_wdata;
    logic [7:0]  seg_out;
    logic [7:0]  an_out;

    int passed = 0;
    int total  = 0;
    int ecount = 0;   // rising edges since the last reset release

    // Active-low glyphs for hex 0..F, dp off.
    logic [7:0] gl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    seg_scan_driver #(
        .SCAN_DIV   (4),
        .ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_wen   (seg_wen),
        .seg_wdata (seg_wdata),
        .seg_out   (seg_out),
        .an_out    (an_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        ecount++;
    endtask

    // Digit shown after edge ecount: each digit holds for 4 edges starting at edge 1.
    function automatic int exp_digit;
        exp_digit = ((ecount - 1) / 4) % 8;
    endfunction

    function automatic logic [7:0] exp_an(input int d);
        logic [7:0] one;
        one    = 8'h01;
        exp_an = ~(one << d);
    endfunction

    function automatic logic [3:0] nib(input logic [31:0] v, input int d);
        nib = v[d*4 +: 4];
    endfunction

    task automatic do_write(input logic [31:0] v);
        seg_wen   = 1'b1;
        seg_wdata = v;
        tick();
        seg_wen   = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b0; seg_wen = 1'b0; seg_wdata = 32'd0;
        #1 rst = 1'b1;
        #1;
        total++;
        if (an_out !== 8'hFF || seg_out !== 8'hFF)
            $display("FAIL reset_idle: an=%h seg=%h required an=ff seg=ff", an_out, seg_out);
        else passed++;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        ecount = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            total++;
            if (an_out !== exp_an(exp_digit()) || seg_out !== 8'hC0)
                $display("FAIL scan_nowrite edge %0d: an=%h seg=%h required an=%h seg=c0",
                         ecount, an_out, seg_out, exp_an(exp_digit()));
            else passed++;
        end
    endtask

    task automatic test_write;
        logic [31:0] v;
        v = 32'h1234ABCD;
        do_write(v);
        for (int i = 0; i < 33; i++) begin
            tick();
            total++;
            if (an_out !== exp_an(exp_digit()) || seg_out !== gl[nib(v, exp_digit())])
                $display("FAIL write_1234abcd edge %0d: an=%h seg=%h required an=%h seg=%h",
                         ecount, an_out, seg_out, exp_an(exp_digit()), gl[nib(v, exp_digit())]);
            else passed++;
            if (exp_digit() == 0) begin
                total++;
                if (seg_out !== 8'hA1) $display("FAIL digit0_d: seg=%h required a1", seg_out);
                else passed++;
            end
            if (exp_digit() == 7) begin
                total++;
                if (seg_out !== 8'hF9) $display("FAIL digit7_1: seg=%h required f9", seg_out);
                else passed++;
            end
        end
    endtask

    task automatic test_back_to_back;
        do_write(32'h0000_0000);
        do_write(32'hFFFF_FFFF);
        for (int i = 0; i < 34; i++) begin
            tick();
            total++;
            if (an_out !== exp_an(exp_digit()) || seg_out !== 8'h8E)
                $display("FAIL back_to_back edge %0d: an=%h seg=%h required an=%h seg=8e",
                         ecount, an_out, seg_out, exp_an(exp_digit()));
            else passed++;
        end
    endtask

    task automatic test_reset_mid;
        // idx=5, div_cnt=2 holds right after edge 22 of a frame.
        while ((ecount % 32) != 22) tick();
        total++;
        if (an_out !== 8'hDF) $display("FAIL pre_reset_digit5: an=%h required df", an_out);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if (an_out !== 8'hFF || seg_out !== 8'hFF)
            $display("FAIL async_reset: an=%h seg=%h required an=ff seg=ff", an_out, seg_out);
        else passed++;
        seg_wen = 1'b1; seg_wdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        total++;
        if (an_out !== 8'hFF || seg_out !== 8'hFF)
            $display("FAIL reset_hold: an=%h seg=%h required an=ff seg=ff", an_out, seg_out);
        else passed++;
        @(negedge clk);
        seg_wen = 1'b0;
        rst = 1'b0;
        ecount = 0;
        for (int i = 0; i < 9; i++) begin
            tick();
            total++;
            if (an_out !== exp_an(exp_digit()) || seg_out !== 8'hC0)
                $display("FAIL after_reset edge %0d: an=%h seg=%h required an=%h seg=c0",
                         ecount, an_out, seg_out, exp_an(exp_digit()));
            else passed++;
        end
    endtask

    task automatic test_blank;
        logic [31:0] v;
        logic [7:0]  ea, es;
        v = 32'h0000_00A5;
        do_write(v);
        tick();
        for (int i = 0; i < 32; i++) begin
            tick();
            ea = exp_an(exp_digit());
            es = gl[nib(v, exp_digit())];
`ifdef SEG_BLANK_LEADING_ZERO_EN
            if (exp_digit() >= 2) begin
                ea = 8'hFF;
                es = 8'hFF;
            end
`endif
            total++;
            if (an_out !== ea || seg_out !== es)
                $display("FAIL blank_a5 digit %0d: an=%h seg=%h required an=%h seg=%h",
                         exp_digit(), an_out, seg_out, ea, es);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_back_to_back();
        test_reset_mid();
        test_blank();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
